fb_write_ctrl: RTL and testbench

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_px_pack.sv | 64 ++++++
 rtl/fb_write_ctrl.sv | 128 ++++++++++++
 tb/tb_fb_write_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the FTDI-to-framebuffer write controller.
//   - fb_state_e : one-hot controller state (SYNC0, SYNC1, PIX, FULL)
//   - PIX_W      : packed pixel width (7+7+6 bits of R,G,B)
//   - ADDR_W     : framebuffer pixel address width
//   - SYNC*_DEF  : default frame-header bytes
package fb_pkg;

  typedef enum logic [3:0] {
    ST_SYNC0 = 4'b0001,
    ST_SYNC1 = 4'b0010,
    ST_PIX   = 4'b0100,
    ST_FULL  = 4'b1000
  } fb_state_e;

  localparam int PIX_W  = 20;
  localparam int ADDR_W = 14;

  localparam logic [7:0] SYNC0_DEF = 8'hA5;
  localparam logic [7:0] SYNC1_DEF = 8'h5A;

  // Keep the MSBs of each channel: R and G lose one bit, B loses two.
  function automatic logic [PIX_W-1:0] pack_px(input logic [7:0] r,
                                               input logic [7:0] g,
                                               input logic [7:0] b);
    return {r[7:1], g[7:1], b[7:2]};
  endfunction

endpackage

// File: rtl/fb_px_pack.sv
// fb_px_pack: collects R, G, B bytes into one packed framebuffer pixel.
// Ports:
//   clk_i, rst_i   : clock and synchronous active-high reset
//   clr_i          : restart at the R byte (start of a new frame)
//   byte_en_i      : one pixel byte is being accepted this cycle
//   byte_i         : the accepted byte
//   px_done_o      : combinational, the B byte is being accepted this cycle
//   px_we_o        : registered one-cycle strobe, the cycle after the B byte
//   px_data_o      : packed pixel, valid while px_we_o is high, held after
module fb_px_pack
  import fb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             byte_en_i,
  input  logic [7:0]       byte_i,
  output logic             px_done_o,
  output logic             px_we_o,
  output logic [PIX_W-1:0] px_data_o
);

  logic [1:0]       idx_q;
  logic [7:0]       r_q;
  logic [7:0]       g_q;
  logic             we_q;
  logic [PIX_W-1:0] data_q;

  assign px_done_o = byte_en_i && !clr_i && (idx_q == 2'd2);
  assign px_we_o   = we_q;
  assign px_data_o = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= 2'd0;
      r_q    <= 8'd0;
      g_q    <= 8'd0;
      we_q   <= 1'b0;
      data_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (clr_i) begin
        idx_q <= 2'd0;
      end else if (byte_en_i) begin
        case (idx_q)
          2'd0: begin
            r_q   <= byte_i;
            idx_q <= 2'd1;
          end
          2'd1: begin
            g_q   <= byte_i;
            idx_q <= 2'd2;
          end
          default: begin
            data_q <= pack_px(r_q, g_q, byte_i);
            we_q   <= 1'b1;
            idx_q  <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: parses an FTDI byte stream (A5 5A header, then R,G,B bytes
// per pixel) and writes one frame into the back buffer of a double-buffered
// framebuffer. After the last pixel it waits in FULL for frame_start, then
// swaps buffers.
// Ports:
//   clk_60, rst          : 60 MHz clock, synchronous active-high reset
//   rx_valid/rx_data     : incoming byte; accepted when rx_valid && rx_ready
//   rx_ready             : high in SYNC0/SYNC1/PIX, low in FULL
//   frame_start          : display frame pulse (already in clk_60 domain)
//   fb_we/fb_waddr/fb_wdata : registered framebuffer write port
//   fb_sel               : buffer being written (display reads !fb_sel)
//   frame_done           : pulse together with the write of the last pixel
//   overrun              : sticky, a byte was offered while rx_ready was low
//   dbg_state            : current controller state, for observation only
//
// Handshake: a byte transfers in exactly the cycles where rx_valid and
// rx_ready are both high at the rising edge; rx_ready depends only on the
// registered state, never on rx_valid.
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int         FRAME_PIXELS = 16384,
  parameter logic [7:0] SYNC0_BYTE   = SYNC0_DEF,
  parameter logic [7:0] SYNC1_BYTE   = SYNC1_DEF
) (
  input  logic              clk_60,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              frame_start,
  output logic [PIX_W-1:0]  fb_wdata,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic              fb_we,
  output logic              fb_sel,
  output logic              frame_done,
  output logic              overrun,
  output logic [3:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  fb_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              sel_q;
  logic              done_q;
  logic              overrun_q;

  logic rx_accept;
  logic pack_en;
  logic pack_clr;
  logic px_done;

  assign rx_ready  = (state_q != ST_FULL);
  assign rx_accept = rx_valid && rx_ready;
  assign pack_en   = rx_accept && (state_q == ST_PIX);
  // Header completion restarts the packer so a new frame always begins at R.
  assign pack_clr  = rx_accept && (state_q == ST_SYNC1) && (rx_data == SYNC1_BYTE);

  fb_px_pack u_pack (
    .clk_i     (clk_60),
    .rst_i     (rst),
    .clr_i     (pack_clr),
    .byte_en_i (pack_en),
    .byte_i    (rx_data),
    .px_done_o (px_done),
    .px_we_o   (fb_we),
    .px_data_o (fb_wdata)
  );

  always_ff @(posedge clk_60) begin
    if (rst) begin
      state_q   <= ST_SYNC0;
      addr_q    <= '0;
      waddr_q   <= '0;
      sel_q     <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (rx_valid && !rx_ready) overrun_q <= 1'b1;
      case (state_q)
        ST_SYNC0: begin
          if (rx_accept && (rx_data == SYNC0_BYTE)) state_q <= ST_SYNC1;
        end
        ST_SYNC1: begin
          if (rx_accept) begin
            if (rx_data == SYNC1_BYTE) begin
              state_q <= ST_PIX;
              addr_q  <= '0;
            end else if (rx_data != SYNC0_BYTE) begin
              state_q <= ST_SYNC0;
            end
          end
        end
        ST_PIX: begin
          // The write address is captured here so it lines up with the
          // packer's registered write strobe one cycle later.
          if (px_done) begin
            waddr_q <= addr_q;
            if (addr_q == LAST_ADDR) begin
              addr_q  <= '0;
              done_q  <= 1'b1;
              state_q <= ST_FULL;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        ST_FULL: begin
          if (frame_start) begin
            sel_q   <= ~sel_q;
            state_q <= ST_SYNC0;
          end
        end
        default: state_q <= ST_SYNC0;
      endcase
    end
  end

  assign fb_waddr   = waddr_q;
  assign fb_sel     = sel_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
module tb_fb_write_ctrl;
  import fb_pkg::*;

  localparam int FP = 4;

  // clock / reset
  logic clk_60 = 1'b0;
  logic rst = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic frame_start = 1'b0;
  logic rx_ready, fb_we, fb_sel, frame_done, overrun;
  logic [19:0] fb_wdata;
  logic [13:0] fb_waddr;
  logic [3:0] dbg_state;

  always #8 clk_60 = ~clk_60;

  fb_write_ctrl #(.FRAME_PIXELS(FP)) dut (
    .clk_60(clk_60), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .frame_start(frame_start), .fb_wdata(fb_wdata),
    .fb_waddr(fb_waddr), .fb_we(fb_we), .fb_sel(fb_sel),
    .frame_done(frame_done), .overrun(overrun), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  // scoreboard entries: {frame_done, addr[13:0], data[19:0]}
  logic [34:0] exp_q[$];

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference pixel: keep top 7/7/6 bits of R/G/B, R most significant
  function automatic logic [19:0] model_px(input int r, input int g, input int b);
    int v;
    v = (r / 2) * 8192 + (g / 2) * 64 + (b / 4);
    return v[19:0];
  endfunction

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic send(input logic [7:0] b, input logic fs = 1'b0);
    rx_valid = 1'b1;
    rx_data = b;
    frame_start = fs;
    @(posedge clk_60); #1;
    rx_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(posedge clk_60); #1;
    frame_start = 1'b0;
  endtask

  task automatic send_pixel(input int addr, input logic fs_last = 1'b0,
                            input logic fixed = 1'b0);
    int r, g, b;
    if (fixed) begin
      r = 255; g = 0; b = 128;
    end else begin
      r = $urandom_range(0, 255);
      g = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
    end
    exp_q.push_back({(addr == FP - 1), 14'(addr), model_px(r, g, b)});
    send(8'(r));
    send(8'(g));
    send(8'(b), fs_last);
  endtask

  task automatic send_frame(input logic fs_last = 1'b0, input logic first_fixed = 1'b0);
    send(8'hA5);
    send(8'h5A);
    for (int p = 0; p < FP; p++)
      send_pixel(p, (p == FP - 1) ? fs_last : 1'b0, (p == 0) ? first_fixed : 1'b0);
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk_60) begin
    if (!rst) begin
      if (fb_we) begin
        if (exp_q.size() == 0) chk("unexpected_we", fb_we, 35'd0);
        else chk("write", {frame_done, fb_waddr, fb_wdata}, exp_q.pop_front());
      end else if (frame_done) begin
        chk("done_without_we", frame_done, 35'd0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk_60);
    #1;
    chk("rst_we", fb_we, 0);
    chk("rst_sel", fb_sel, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_waddr", fb_waddr, 0);
    chk("rst_wdata", fb_wdata, 0);
    chk("rst_ready", rx_ready, 1);
    chk("rst_state", dbg_state, ST_SYNC0);
    rst = 1'b0;

    // frame 1, first pixel FF 00 80
    send_frame(1'b0, 1'b1);
    chk("f1_done", frame_done, 1);
    chk("f1_last_addr", fb_waddr, FP - 1);
    chk("f1_ready_low", rx_ready, 0);
    chk("f1_state_full", dbg_state, ST_FULL);
    chk("f1_sel_hold", fb_sel, 0);

    // bytes offered in FULL are dropped and flag overrun
    send(8'h33);
    send(8'h44);
    chk("ovr_set", overrun, 1);
    chk("ovr_still_full", dbg_state, ST_FULL);
    chk("ovr_no_we", fb_we, 0);

    // swap
    pulse_fs();
    chk("swap_sel", fb_sel, 1);
    chk("swap_state", dbg_state, ST_SYNC0);
    chk("swap_ready", rx_ready, 1);

    // frame 2, frame_start together with the final B byte is ignored
    send_frame(1'b1);
    chk("f2_done", frame_done, 1);
    chk("f2_no_toggle", fb_sel, 1);
    chk("f2_state_full", dbg_state, ST_FULL);
    chk("ovr_sticky", overrun, 1);
    repeat (2) @(posedge clk_60);
    #1;
    chk("f2_wait_sel", fb_sel, 1);
    pulse_fs();
    chk("f2_swap_sel", fb_sel, 0);

    // header with leading junk and repeated A5
    send(8'h00);
    send(8'hA5);
    send(8'hA5);
    send(8'h5A);
    chk("hdr_state_pix", dbg_state, ST_PIX);
    send_pixel(0);
    // two bytes of the next pixel, then reset with the B byte, frame_start
    send(8'($urandom_range(0, 255)));
    send(8'($urandom_range(0, 255)));
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hC3;
    frame_start = 1'b1;
    @(posedge clk_60); #1;
    rst = 1'b0;
    rx_valid = 1'b0;
    frame_start = 1'b0;
    chk("mid_rst_we", fb_we, 0);
    chk("mid_rst_waddr", fb_waddr, 0);
    chk("mid_rst_wdata", fb_wdata, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_sel", fb_sel, 0);
    chk("mid_rst_state", dbg_state, ST_SYNC0);

    // broken header A5 11 5A produces no write
    send(8'hA5);
    send(8'h11);
    send(8'h5A);
    chk("bad_hdr_state", dbg_state, ST_SYNC0);

    // fresh frame after reset writes from address 0 into buffer 0
    send_frame();
    chk("f3_done", frame_done, 1);
    chk("f3_sel", fb_sel, 0);

    repeat (3) @(posedge clk_60);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
